// File: rtl/mdp3_feed_arbiter.sv
// Message-granular arbiter between redundant CME MDP3 feeds A and B.
// Forwards each sequence number once, in order; drops duplicates and counts gaps.
module mdp3_feed_arbiter #(
  parameter int DATA_W = 64,
  parameter int SEQ_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_first,
  input  logic              a_last,
  input  logic [SEQ_W-1:0]  a_seq,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_first,
  input  logic              b_last,
  input  logic [SEQ_W-1:0]  b_seq,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  input  logic              out_ready,
  output logic [SEQ_W-1:0]  expected_seq,
  output logic              synced,
  output logic              gap_pulse,
  output logic [CNT_W-1:0]  gap_count,
  output logic [CNT_W-1:0]  dup_count
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               grant_q, grant_d;   // 0 = feed A, 1 = feed B
  logic               rr_q, rr_d;
  logic [SEQ_W-1:0]   msg_seq_q, msg_seq_d;
  logic [SEQ_W-1:0]   expected_seq_q, expected_seq_d;
  logic               synced_q, synced_d;
  logic               gap_pulse_q, gap_pulse_d;
  logic [CNT_W-1:0]   gap_count_q, gap_count_d;
  logic [CNT_W-1:0]   dup_count_q, dup_count_d;

  logic               a_cand, b_cand, pick_b;
  logic [SEQ_W-1:0]   cand_seq, diff;
  logic               g_valid, g_first, g_last;
  logic [DATA_W-1:0]  g_data;

  assign a_cand   = a_valid && a_first;
  assign b_cand   = b_valid && b_first;
  assign pick_b   = (a_cand && b_cand) ? rr_q : b_cand;
  assign cand_seq = pick_b ? b_seq : a_seq;
  // Modular distance: MSB set means the candidate is behind (duplicate or replay).
  assign diff     = cand_seq - expected_seq_q;

  assign g_valid  = grant_q ? b_valid : a_valid;
  assign g_data   = grant_q ? b_data  : a_data;
  assign g_first  = grant_q ? b_first : a_first;
  assign g_last   = grant_q ? b_last  : a_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      rr_q           <= 1'b0;
      msg_seq_q      <= '0;
      expected_seq_q <= '0;
      synced_q       <= 1'b0;
      gap_pulse_q    <= 1'b0;
      gap_count_q    <= '0;
      dup_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_q           <= rr_d;
      msg_seq_q      <= msg_seq_d;
      expected_seq_q <= expected_seq_d;
      synced_q       <= synced_d;
      gap_pulse_q    <= gap_pulse_d;
      gap_count_q    <= gap_count_d;
      dup_count_q    <= dup_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    msg_seq_d      = msg_seq_q;
    expected_seq_d = expected_seq_q;
    synced_d       = synced_q;
    gap_pulse_d    = 1'b0;
    gap_count_d    = gap_count_q;
    dup_count_d    = dup_count_q;
    case (state_q)
      IDLE: begin
        if (a_cand || b_cand) begin
          grant_d   = pick_b;
          rr_d      = !pick_b;
          msg_seq_d = cand_seq;
          if (!synced_q || !diff[SEQ_W-1]) begin
            state_d = FWD;
            if (synced_q && (diff != '0)) begin
              gap_pulse_d = 1'b1;
              if (gap_count_q != CNT_MAX) gap_count_d = gap_count_q + CNT_W'(1);
            end
          end else begin
            state_d = DROP;
            if (dup_count_q != CNT_MAX) dup_count_d = dup_count_q + CNT_W'(1);
          end
        end
      end
      FWD: begin
        if (g_valid && out_ready && g_last) begin
          expected_seq_d = msg_seq_q + SEQ_W'(1);
          synced_d       = 1'b1;
          state_d        = IDLE;
        end
      end
      DROP: begin
        if (g_valid && g_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        // Mid-message beats with no owner are swallowed to resynchronise framing.
        a_ready = a_valid && !a_first;
        b_ready = b_valid && !b_first;
      end
      FWD: begin
        out_valid = g_valid;
        out_data  = g_data;
        out_first = g_first;
        out_last  = g_last;
        if (grant_q) b_ready = out_ready;
        else         a_ready = out_ready;
      end
      DROP: begin
        if (grant_q) b_ready = 1'b1;
        else         a_ready = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  assign expected_seq = expected_seq_q;
  assign synced       = synced_q;
  assign gap_pulse    = gap_pulse_q;
  assign gap_count    = gap_count_q;
  assign dup_count    = dup_count_q;

endmodule
